// File: rtl/cbd_poly_collector_if.sv
// Bundle between the CBD polynomial collector and its sampler/consumer side.
// Signal prefixes are from the collector's point of view: i_ into it, o_ out of it.
interface cbd_poly_collector_if #(
  parameter int COEFF_W = 12,
  parameter int WORDS   = 64
);
  localparam int DATA_W = 4 * COEFF_W;
  localparam int AW     = $clog2(WORDS);
  localparam int CW     = $clog2(WORDS) + 1;

  logic              i_go;
  logic              o_smp_start;
  logic              i_smp_valid;
  logic [DATA_W-1:0] i_smp_data;
  logic              i_release;
  logic [AW-1:0]     i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_poly_valid;
  logic              o_busy;
  logic [CW-1:0]     o_word_cnt;
  logic              o_range_err;
  logic              o_overflow;

  modport slave (
    input  i_go, i_smp_valid, i_smp_data, i_release, i_rd_addr,
    output o_smp_start, o_rd_data, o_poly_valid, o_busy, o_word_cnt,
           o_range_err, o_overflow
  );

  modport master (
    output i_go, i_smp_valid, i_smp_data, i_release, i_rd_addr,
    input  o_smp_start, o_rd_data, o_poly_valid, o_busy, o_word_cnt,
           o_range_err, o_overflow
  );
endinterface

// File: rtl/cbd_poly_collector.sv
// Collects one 256-coefficient eta=2 CBD polynomial from the sampler stream,
// maps negative coefficients into [0,Q) and serves it on a registered read port.
module cbd_poly_collector #(
  parameter int Q       = 3329,
  parameter int COEFF_W = 12,
  parameter int WORDS   = 64
) (
  input logic                  clk,
  input logic                  reset,
  cbd_poly_collector_if.slave  bus
);
  localparam int DATA_W = 4 * COEFF_W;
  localparam int AW     = $clog2(WORDS);
  localparam int CW     = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_FULL} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_word_cnt;
  logic              r_smp_start;
  logic              r_poly_valid;
  logic              r_busy;
  logic              r_range_err;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [WORDS];

  logic [DATA_W-1:0] w_mapped;
  logic              w_bad;
  logic              w_accept;

  // Negative two's-complement coefficients wrap to c+Q; 12-bit truncation is the mod 2^12.
  function automatic logic [COEFF_W-1:0] f_map(input logic signed [COEFF_W-1:0] c);
    logic [COEFF_W-1:0] u;
    logic [COEFF_W-1:0] q_w;
    u   = c;
    q_w = COEFF_W'(Q);
    return c[COEFF_W-1] ? (u + q_w) : u;
  endfunction

  // An eta=2 CBD sample can only be one of -2..2.
  function automatic logic f_legal(input logic signed [COEFF_W-1:0] c);
    logic signed [COEFF_W-1:0] lo;
    logic signed [COEFF_W-1:0] hi;
    lo = COEFF_W'(-2);
    hi = COEFF_W'(2);
    return (c >= lo) && (c <= hi);
  endfunction

  assign w_accept = bus.i_smp_valid && ((r_state == S_REQ) || (r_state == S_COLLECT));

  // Map all four coefficients of the incoming word and flag any illegal encoding.
  always_comb begin
    w_mapped = '0;
    w_bad    = 1'b0;
    for (int j = 0; j < 4; j++) begin
      w_mapped[j*COEFF_W +: COEFF_W] = f_map(bus.i_smp_data[j*COEFF_W +: COEFF_W]);
      if (!f_legal(bus.i_smp_data[j*COEFF_W +: COEFF_W])) w_bad = 1'b1;
    end
  end

  // Collection control: sampler request, word counting, sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_word_cnt   <= '0;
      r_smp_start  <= 1'b0;
      r_poly_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_range_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_go) begin
            r_state     <= S_REQ;
            r_word_cnt  <= '0;
            r_range_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_smp_start <= 1'b1;
            r_busy      <= 1'b1;
          end else if (bus.i_smp_valid) begin
            r_overflow  <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.i_smp_valid) begin
            r_state     <= S_COLLECT;
            r_word_cnt  <= r_word_cnt + 1'b1;
            r_range_err <= r_range_err | w_bad;
          end
        end
        S_COLLECT: begin
          if (bus.i_smp_valid) begin
            r_word_cnt  <= r_word_cnt + 1'b1;
            r_range_err <= r_range_err | w_bad;
            if (r_word_cnt == CW'(WORDS - 1)) begin
              r_state      <= S_FULL;
              r_smp_start  <= 1'b0;
              r_busy       <= 1'b0;
              r_poly_valid <= 1'b1;
            end
          end
        end
        S_FULL: begin
          // A late word (e.g. the sampler's trailing word) is dropped, not stored.
          if (bus.i_smp_valid) r_overflow <= 1'b1;
          if (bus.i_release) begin
            r_state      <= S_IDLE;
            r_poly_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Coefficient buffer write; contents carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_word_cnt[AW-1:0]] <= w_mapped;
  end

  // Registered read port, one-cycle latency, independent of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_mem[bus.i_rd_addr];
  end

  assign bus.o_smp_start  = r_smp_start;
  assign bus.o_poly_valid = r_poly_valid;
  assign bus.o_busy       = r_busy;
  assign bus.o_word_cnt   = r_word_cnt;
  assign bus.o_range_err  = r_range_err;
  assign bus.o_overflow   = r_overflow;
  assign bus.o_rd_data    = r_rd_data;
endmodule
